// File: rtl/frv_cf_sequencer_pkg.sv
// Shared constants and types for the control-flow sequencer: port indices,
// FSM encoding and the priority-encoder grant bundle.
package frv_cf_sequencer_pkg;

  localparam int XL        = 31;
  localparam int CF_NPORTS = 3;

  localparam logic [1:0] CF_PORT_TRAP = 2'd0;
  localparam logic [1:0] CF_PORT_XRET = 2'd1;
  localparam logic [1:0] CF_PORT_BR   = 2'd2;

  typedef enum logic {
    CF_IDLE = 1'b0,
    CF_BUSY = 1'b1
  } cf_state_e;

  typedef struct packed {
    logic                 vld;
    logic [CF_NPORTS-1:0] gnt;
    logic [1:0]           idx;
  } cf_grant_t;

endpackage

// File: rtl/frv_cf_prio_enc.sv
// Fixed-priority encoder over the three control-flow requesters:
// trap beats xret beats branch.
module frv_cf_prio_enc
  import frv_cf_sequencer_pkg::*;
(
  input  logic [CF_NPORTS-1:0] req,
  output cf_grant_t            grant
);

  always_comb begin
    grant = '0;
    if (req[CF_PORT_TRAP]) begin
      grant.vld               = 1'b1;
      grant.gnt[CF_PORT_TRAP] = 1'b1;
      grant.idx               = CF_PORT_TRAP;
    end else if (req[CF_PORT_XRET]) begin
      grant.vld               = 1'b1;
      grant.gnt[CF_PORT_XRET] = 1'b1;
      grant.idx               = CF_PORT_XRET;
    end else if (req[CF_PORT_BR]) begin
      grant.vld               = 1'b1;
      grant.gnt[CF_PORT_BR]   = 1'b1;
      grant.idx               = CF_PORT_BR;
    end
  end

endmodule

// File: rtl/frv_cf_sequencer.sv
// Arbitrates trap / xRET / branch control-flow changes onto the single
// front-end cf_req/cf_target/cf_ack channel and counts completed changes.
module frv_cf_sequencer
  import frv_cf_sequencer_pkg::*;
#(
  parameter int XL                = frv_cf_sequencer_pkg::XL,
  parameter int REGISTERED_OUTPUT = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        trap_req,
  input  logic [XL:0] trap_target,
  output logic        trap_ack,
  input  logic        xret_req,
  input  logic [XL:0] xret_target,
  output logic        xret_ack,
  input  logic        br_req,
  input  logic [XL:0] br_target,
  output logic        br_ack,
  output logic        cf_req,
  output logic [XL:0] cf_target,
  input  logic        cf_ack,
  output logic        busy,
  output logic [31:0] cf_count
);

  cf_state_e            state_q, state_d;
  cf_grant_t            win;
  logic [XL:0]          win_tgt;
  logic [CF_NPORTS-1:0] gnt_q;
  logic [XL:0]          tgt_q;
  logic [31:0]          cf_count_q;
  logic                 ack_vld;
  logic [CF_NPORTS-1:0] ack_gnt;
  logic                 comb_present;

  frv_cf_prio_enc u_prio_enc (
    .req   ({br_req, xret_req, trap_req}),
    .grant (win)
  );

  always_comb begin
    case (win.idx)
      CF_PORT_TRAP: win_tgt = trap_target;
      CF_PORT_XRET: win_tgt = xret_target;
      default:      win_tgt = br_target;
    endcase
  end

  // In the unregistered build the winner is offered to the front-end while
  // still IDLE, so a same-cycle ack completes without ever latching a grant.
  assign comb_present = (REGISTERED_OUTPUT == 0) && (state_q == CF_IDLE) && win.vld;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= CF_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CF_IDLE: if (win.vld && !(comb_present && cf_ack)) state_d = CF_BUSY;
      CF_BUSY: if (cf_ack) state_d = CF_IDLE;
      default: state_d = CF_IDLE;
    endcase
  end

  always_comb begin
    cf_req    = 1'b0;
    cf_target = tgt_q;
    ack_vld   = 1'b0;
    ack_gnt   = gnt_q;
    case (state_q)
      CF_IDLE: if (comb_present) begin
        cf_req    = 1'b1;
        cf_target = win_tgt;
        ack_vld   = cf_ack;
        ack_gnt   = win.gnt;
      end
      CF_BUSY: begin
        cf_req  = 1'b1;
        ack_vld = cf_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      gnt_q      <= '0;
      tgt_q      <= '0;
      cf_count_q <= '0;
    end else begin
      if (state_q == CF_IDLE && state_d == CF_BUSY) begin
        gnt_q <= win.gnt;
        tgt_q <= win_tgt;
      end
      if (ack_vld) cf_count_q <= cf_count_q + 32'd1;
    end
  end

  assign trap_ack = ack_vld & ack_gnt[CF_PORT_TRAP];
  assign xret_ack = ack_vld & ack_gnt[CF_PORT_XRET];
  assign br_ack   = ack_vld & ack_gnt[CF_PORT_BR];
  assign busy     = (state_q == CF_BUSY);
  assign cf_count = cf_count_q;

endmodule
